// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle RV32I controller and its datapath.
// master = controller side, slave = datapath/instruction-register side.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] imm_src;
  logic       reg_write;
  logic       instr_done;
  logic       halted;

  modport master (
    input  op, funct3, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, alu_op, imm_src, reg_write, instr_done, halted
  );

  modport slave (
    output op, funct3, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, alu_op, imm_src, reg_write, instr_done, halted
  );
endinterface

// File: rtl/multicycle_controller.sv
// Main Moore control FSM of the multicycle RV32I core; stalls on mem_ready.
// state | meaning
// FETCH/DECODE | read instr, PC+4 / branch target into ALUOut
// MEMADR/MEMREAD/MEMWB/MEMWRITE | load/store address, access, writeback
// EXECUTER/EXECUTEI/ALUWB | ALU op on reg/imm, writeback to rd
// BEQ/JAL/HALT | compare+branch, jump+link, parked until reset
module multicycle_controller (
  input logic                    clk,
  input logic                    reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_t state_q, state_d;

  logic       adr_src_c, mem_write_c, ir_write_c, reg_write_c;
  logic       instr_done_c, halted_c, branch_c, pc_update_c;
  logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, alu_op_c, imm_src_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    adr_src_c    = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    instr_done_c = 1'b0;
    halted_c     = 1'b0;
    branch_c     = 1'b0;
    pc_update_c  = 1'b0;
    result_src_c = 2'b00;
    alu_src_a_c  = 2'b00;
    alu_src_b_c  = 2'b00;
    alu_op_c     = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        ir_write_c   = bus.mem_ready;
        pc_update_c  = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b01;
        if (bus.op == OP_LOAD || bus.op == OP_STORE)     state_d = S_MEMADR;
        else if (bus.op == OP_RTYPE)                     state_d = S_EXECUTER;
        else if (bus.op == OP_ITYPE)                     state_d = S_EXECUTEI;
        else if (bus.op == OP_BEQ && bus.funct3 == 3'b000) state_d = S_BEQ;
        else if (bus.op == OP_JAL)                       state_d = S_JAL;
        else                                             state_d = S_HALT;
      end
      S_MEMADR: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        state_d     = (bus.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src_c = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_c = 2'b01;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_c    = 1'b1;
        mem_write_c  = 1'b1;
        instr_done_c = bus.mem_ready;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXECUTER: begin
        alu_src_a_c = 2'b10;
        alu_op_c    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a_c = 2'b10;
        alu_src_b_c = 2'b01;
        alu_op_c    = 2'b10;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_c  = 2'b10;
        alu_op_c     = 2'b01;
        branch_c     = 1'b1;
        instr_done_c = 1'b1;
        state_d      = S_FETCH;
      end
      // jal retires in the ALUWB that writes rd, so no done pulse here
      S_JAL: begin
        alu_src_a_c = 2'b01;
        alu_src_b_c = 2'b10;
        pc_update_c = 1'b1;
        state_d     = S_ALUWB;
      end
      S_HALT: begin
        halted_c = 1'b1;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    imm_src_c = 2'b00;
    case (bus.op)
      OP_STORE: imm_src_c = 2'b01;
      OP_BEQ:   imm_src_c = 2'b10;
      OP_JAL:   imm_src_c = 2'b11;
      default:  imm_src_c = 2'b00;
    endcase
  end

  // Write strobes are gated so none can fire while reset is held
  assign bus.pc_write   = ~reset & ((branch_c & bus.zero) | pc_update_c);
  assign bus.ir_write   = ~reset & ir_write_c;
  assign bus.mem_write  = ~reset & mem_write_c;
  assign bus.reg_write  = ~reset & reg_write_c;
  assign bus.adr_src    = adr_src_c;
  assign bus.result_src = result_src_c;
  assign bus.alu_src_a  = alu_src_a_c;
  assign bus.alu_src_b  = alu_src_b_c;
  assign bus.alu_op     = alu_op_c;
  assign bus.imm_src    = imm_src_c;
  assign bus.instr_done = instr_done_c;
  assign bus.halted     = halted_c;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: opcode table, hand-written
// corner sequences, and randomized mem_ready against a phase-list model.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;
    logic [1:0] imm;
    int         cycles;
    int         rw;
    int         pw;
    bit         halt;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f, input logic z);
    bus.op     = o;
    bus.funct3 = f;
    bus.zero   = z;
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    chk("rst_enables", int'(bus.pc_write) + int'(bus.ir_write) + int'(bus.mem_write) + int'(bus.reg_write), 0);
    chk("rst_halted", int'(bus.halted), 0);
    chk("rst_alu_src_b", int'(bus.alu_src_b), 2);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reference model: each instruction is a list of phases; phases that talk
  // to memory (fetch, load read, store write) wait for mem_ready.
  task automatic run_model(input int kind);
    logic [6:0] opv;
    logic [7:0] waitm;
    logic       z, mr;
    int len, p, cyc, exp_cyc, done_cyc, n_done, rw, pw, mw, exp_mw, exp_rw, exp_pw;
    z = 1'($urandom_range(0, 1));
    case (kind)
      0:       begin opv = 7'b0110011; len = 4; waitm = 8'b0000_0001; end
      1:       begin opv = 7'b0010011; len = 4; waitm = 8'b0000_0001; end
      2:       begin opv = 7'b0000011; len = 5; waitm = 8'b0000_1001; end
      3:       begin opv = 7'b0100011; len = 4; waitm = 8'b0000_1001; end
      4:       begin opv = 7'b1100011; len = 3; waitm = 8'b0000_0001; end
      default: begin opv = 7'b1101111; len = 4; waitm = 8'b0000_0001; end
    endcase
    set_instr(opv, (kind == 4) ? 3'b000 : 3'($urandom_range(0, 7)), z);
    exp_rw = (kind == 0 || kind == 1 || kind == 2 || kind == 5) ? 1 : 0;
    exp_pw = 1 + ((kind == 5) ? 1 : 0) + ((kind == 4 && z) ? 1 : 0);
    p = 0; cyc = 0; exp_cyc = 0; done_cyc = 0; n_done = 0;
    rw = 0; pw = 0; mw = 0; exp_mw = 0;
    while (p < len && cyc < 80) begin
      cyc++;
      mr = (cyc > 40) ? 1'b1 : 1'($urandom_range(0, 1));
      bus.mem_ready = mr;
      #1;
      if (bus.instr_done) begin
        n_done++;
        if (done_cyc == 0) done_cyc = cyc;
      end
      if (bus.reg_write) rw++;
      if (bus.pc_write)  pw++;
      if (bus.mem_write) mw++;
      if (kind == 3 && p == 3) exp_mw++;
      if (!(waitm[p] && !mr)) p++;
      if (p == len) exp_cyc = cyc;
      tick();
    end
    chk("rnd_done_cycle", done_cyc, exp_cyc);
    chk("rnd_done_count", n_done, 1);
    chk("rnd_reg_write", rw, exp_rw);
    chk("rnd_pc_write", pw, exp_pw);
    chk("rnd_mem_write", mw, exp_mw);
  endtask

  initial begin
    int cyc, rw, pw, done_cyc, halt_cyc, n_done;
    bit fin;

    tbl[0] = '{7'b0110011, 3'b000, 1'b0, 2'b00, 4, 1, 1, 1'b0};
    tbl[1] = '{7'b0010011, 3'b000, 1'b0, 2'b00, 4, 1, 1, 1'b0};
    tbl[2] = '{7'b0000011, 3'b010, 1'b0, 2'b00, 5, 1, 1, 1'b0};
    tbl[3] = '{7'b0100011, 3'b010, 1'b0, 2'b01, 4, 0, 1, 1'b0};
    tbl[4] = '{7'b1100011, 3'b000, 1'b1, 2'b10, 3, 0, 2, 1'b0};
    tbl[5] = '{7'b1100011, 3'b000, 1'b0, 2'b10, 3, 0, 1, 1'b0};
    tbl[6] = '{7'b1101111, 3'b000, 1'b0, 2'b11, 4, 1, 2, 1'b0};
    tbl[7] = '{7'b1100011, 3'b001, 1'b1, 2'b10, 3, 0, 1, 1'b1};
    tbl[8] = '{7'b1111111, 3'b000, 1'b0, 2'b00, 3, 0, 1, 1'b1};
    tbl[9] = '{7'b0110111, 3'b000, 1'b0, 2'b00, 3, 0, 1, 1'b1};

    set_instr(7'b0100011, 3'b000, 1'b0);
    bus.mem_ready = 1'b1;
    do_reset();

    for (int i = 0; i < 10; i++) begin
      set_instr(tbl[i].op, tbl[i].f3, tbl[i].z);
      bus.mem_ready = 1'b1;
      cyc = 0; rw = 0; pw = 0; done_cyc = 0; halt_cyc = 0; n_done = 0; fin = 0;
      while (!fin && cyc < 12) begin
        cyc++;
        #1;
        if (cyc == 1) chk($sformatf("tbl%0d_imm_src", i), int'(bus.imm_src), int'(tbl[i].imm));
        if (bus.reg_write) rw++;
        if (bus.pc_write) pw++;
        if (bus.instr_done) begin n_done++; done_cyc = cyc; fin = 1; end
        if (bus.halted) begin halt_cyc = cyc; fin = 1; end
        tick();
      end
      chk($sformatf("tbl%0d_cycles", i), tbl[i].halt ? halt_cyc : done_cyc, tbl[i].cycles);
      chk($sformatf("tbl%0d_reg_write", i), rw, tbl[i].rw);
      chk($sformatf("tbl%0d_pc_write", i), pw, tbl[i].pw);
      chk($sformatf("tbl%0d_done_count", i), n_done, tbl[i].halt ? 0 : 1);
      if (tbl[i].halt) begin
        #1;
        chk($sformatf("tbl%0d_halt_stays", i), int'(bus.halted), 1);
        chk($sformatf("tbl%0d_halt_enables", i),
            int'(bus.pc_write) + int'(bus.ir_write) + int'(bus.mem_write) +
            int'(bus.reg_write) + int'(bus.instr_done), 0);
        do_reset();
        #1;
        chk($sformatf("tbl%0d_post_rst_halted", i), int'(bus.halted), 0);
        chk($sformatf("tbl%0d_post_rst_ir_write", i), int'(bus.ir_write), 1);
      end
    end

    // add x3,x1,x2 cycle by cycle
    set_instr(7'b0110011, 3'b000, 1'b0);
    bus.mem_ready = 1'b1;
    #1;
    chk("add_c1_ir_write", int'(bus.ir_write), 1);
    chk("add_c1_pc_write", int'(bus.pc_write), 1);
    chk("add_c1_result_src", int'(bus.result_src), 2);
    tick(); #1;
    chk("add_c2_alu_src_a", int'(bus.alu_src_a), 1);
    chk("add_c2_ir_write", int'(bus.ir_write), 0);
    tick(); #1;
    chk("add_c3_alu_op", int'(bus.alu_op), 2);
    chk("add_c3_alu_src_b", int'(bus.alu_src_b), 0);
    chk("add_c3_reg_write", int'(bus.reg_write), 0);
    tick(); #1;
    chk("add_c4_reg_write", int'(bus.reg_write), 1);
    chk("add_c4_instr_done", int'(bus.instr_done), 1);
    tick();

    // lw with two stall cycles in MEMREAD
    set_instr(7'b0000011, 3'b010, 1'b0);
    rw = 0;
    for (int c = 1; c <= 7; c++) begin
      bus.mem_ready = (c == 4 || c == 5) ? 1'b0 : 1'b1;
      #1;
      if (bus.reg_write) begin
        rw++;
        chk("lw_wb_result_src", int'(bus.result_src), 1);
      end
      if (c >= 4 && c <= 6) chk($sformatf("lw_c%0d_adr_src", c), int'(bus.adr_src), 1);
      chk($sformatf("lw_c%0d_done", c), int'(bus.instr_done), (c == 7) ? 1 : 0);
      tick();
    end
    chk("lw_reg_write_count", rw, 1);

    // beq: zero selects pc_write in the BEQ cycle
    for (int zz = 1; zz >= 0; zz--) begin
      set_instr(7'b1100011, 3'b000, 1'(zz));
      bus.mem_ready = 1'b1;
      tick(); tick(); #1;
      chk($sformatf("beq_z%0d_alu_op", zz), int'(bus.alu_op), 1);
      chk($sformatf("beq_z%0d_pc_write", zz), int'(bus.pc_write), zz);
      chk($sformatf("beq_z%0d_done", zz), int'(bus.instr_done), 1);
      tick();
    end

    // jal: pc_write in JAL cycle, single done in ALUWB
    set_instr(7'b1101111, 3'b000, 1'b0);
    tick(); tick(); #1;
    chk("jal_c3_pc_write", int'(bus.pc_write), 1);
    chk("jal_c3_done", int'(bus.instr_done), 0);
    chk("jal_c3_alu_src_b", int'(bus.alu_src_b), 2);
    tick(); #1;
    chk("jal_c4_reg_write", int'(bus.reg_write), 1);
    chk("jal_c4_result_src", int'(bus.result_src), 0);
    chk("jal_c4_done", int'(bus.instr_done), 1);
    tick();

    // async reset while a store is stalled in MEMWRITE
    set_instr(7'b0100011, 3'b010, 1'b0);
    bus.mem_ready = 1'b1;
    tick(); tick(); tick();
    bus.mem_ready = 1'b0;
    #1;
    chk("sw_stall_mem_write", int'(bus.mem_write), 1);
    #1;
    chk("sw_stall_held", int'(bus.mem_write), 1);
    reset = 1'b1;
    #1;
    chk("sw_rst_mem_write", int'(bus.mem_write), 0);
    bus.mem_ready = 1'b1;
    #1;
    chk("sw_rst_ir_write", int'(bus.ir_write), 0);
    chk("sw_rst_pc_write", int'(bus.pc_write), 0);
    tick();
    reset = 1'b0;
    #1;
    chk("sw_post_adr_src", int'(bus.adr_src), 0);
    chk("sw_post_ir_write", int'(bus.ir_write), 1);
    chk("sw_post_mem_write", int'(bus.mem_write), 0);

    do_reset();
    for (int n = 0; n < 200; n++) run_model(int'($urandom_range(0, 5)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
